// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-sample majority vote, false-start
// rejection, parity/frame/break/overrun reporting and a valid/ready output register.
module uart_rx_cfg #(
  parameter int CLOCK_HZ   = 12500000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] read_data,
  output logic                 read_valid,
  input  logic                 read_ready,
  output logic                 parity_error,
  output logic                 frame_error,
  output logic                 break_detect,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CPS = CLOCK_HZ / (BAUD * OVERSAMPLE);
  localparam int CW  = (CPS > 1) ? $clog2(CPS) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CLK_MAX   = CW'(CPS - 1);
  localparam logic [SW-1:0] S_A       = SW'(OVERSAMPLE / 2 - 2);
  localparam logic [SW-1:0] S_B       = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_RES     = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_END     = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY == 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t                 state, state_next;
  logic                   rx_meta, rx_s, line_armed;
  logic [CW-1:0]          clk_cnt;
  logic [SW-1:0]          samp_cnt;
  logic [BW-1:0]          bit_cnt;
  logic                   samp_a, samp_b;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_err, ferr_acc, seen_one;
  logic                   tick, resolve, bit_end, vote, brk, complete;

  // Sample ticks are numbered from 1 at the first tick of a bit, so samp_cnt is tick-1;
  // the three votes straddle the bit centre.
  assign tick    = (clk_cnt == CLK_MAX);
  assign resolve = tick && (samp_cnt == S_RES);
  assign bit_end = tick && (samp_cnt == S_END);
  assign vote    = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
  assign brk     = ~seen_one & ~vote;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!rx_s && line_armed) state_next = START;
      START:   if (resolve && vote) state_next = IDLE;
               else if (bit_end)    state_next = DATA;
      DATA:    if (bit_end && bit_cnt == DATA_LAST)
                 state_next = (PARITY != 0) ? PAR : STOP;
      PAR:     if (bit_end) state_next = STOP;
      STOP:    if (resolve && bit_cnt == STOP_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    complete = (state == STOP) && resolve && (bit_cnt == STOP_LAST);
  end

  // Control: synchroniser, counters, line arming
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      clk_cnt    <= '0;
      samp_cnt   <= '0;
      bit_cnt    <= '0;
      line_armed <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      if (state == IDLE) begin
        clk_cnt  <= '0;
        samp_cnt <= '0;
      end else if (tick) begin
        clk_cnt  <= '0;
        samp_cnt <= (samp_cnt == S_END) ? '0 : samp_cnt + 1'b1;
      end else begin
        clk_cnt  <= clk_cnt + 1'b1;
      end
      if (state_next != state) bit_cnt <= '0;
      else if (bit_end)        bit_cnt <= bit_cnt + 1'b1;
      // A framing fault leaves the line low; wait for it to return high before re-arming.
      if (complete && (ferr_acc || !vote)) line_armed <= 1'b0;
      else if (rx_s)                       line_armed <= 1'b1;
    end
  end

  // Datapath: vote samples, shift register, per-frame accumulators
  always_ff @(posedge clock) begin
    if (tick && samp_cnt == S_A) samp_a <= rx_s;
    if (tick && samp_cnt == S_B) samp_b <= rx_s;
    if (state == IDLE) begin
      par_err  <= 1'b0;
      ferr_acc <= 1'b0;
      seen_one <= 1'b0;
    end else if (resolve) begin
      case (state)
        DATA: begin
          shreg    <= {vote, shreg[DATA_BITS-1:1]};
          seen_one <= seen_one | vote;
        end
        PAR: begin
          par_err  <= (^shreg) ^ vote ^ ODD;
          seen_one <= seen_one | vote;
        end
        STOP: begin
          ferr_acc <= ferr_acc | ~vote;
          seen_one <= seen_one | vote;
        end
        default: ;
      endcase
    end
  end

  // Output register: data and flags move together, only on load
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      read_data    <= '0;
      read_valid   <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      break_detect <= 1'b0;
      overrun      <= 1'b0;
    end else if (complete) begin
      read_data    <= shreg;
      read_valid   <= 1'b1;
      parity_error <= par_err;
      frame_error  <= ferr_acc | ~vote;
      break_detect <= brk;
      overrun      <= read_valid & ~read_ready;
    end else if (read_valid && read_ready) begin
      read_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three instances (default 8N1 @81 clk/sample, 8N1 @8,
// 8E1 @8) driven from one linear sequence; expected words go through a scoreboard queue.
module tb_uart_rx_cfg;

  typedef struct packed {
    logic [7:0] data;
    logic       pe, fe, bk, ov;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       rx_l  [3];
  logic       rdy   [3];
  logic [7:0] rd    [3];
  logic       vld   [3];
  logic       pe    [3];
  logic       fe    [3];
  logic       bk    [3];
  logic       ov    [3];
  logic       bz    [3];

  exp_t sb[$];
  int   n_err    = 0;
  int   n_checks = 0;

  always #5 clock = ~clock;

  uart_rx_cfg dut0 (
    .clock(clock), .reset_n(reset_n), .rx(rx_l[0]), .read_data(rd[0]), .read_valid(vld[0]),
    .read_ready(rdy[0]), .parity_error(pe[0]), .frame_error(fe[0]), .break_detect(bk[0]),
    .overrun(ov[0]), .busy(bz[0]));

  uart_rx_cfg #(.CLOCK_HZ(1228800)) dut1 (
    .clock(clock), .reset_n(reset_n), .rx(rx_l[1]), .read_data(rd[1]), .read_valid(vld[1]),
    .read_ready(rdy[1]), .parity_error(pe[1]), .frame_error(fe[1]), .break_detect(bk[1]),
    .overrun(ov[1]), .busy(bz[1]));

  uart_rx_cfg #(.CLOCK_HZ(1228800), .PARITY(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .rx(rx_l[2]), .read_data(rd[2]), .read_valid(vld[2]),
    .read_ready(rdy[2]), .parity_error(pe[2]), .frame_error(fe[2]), .break_detect(bk[2]),
    .overrun(ov[2]), .busy(bz[2]));

  function automatic int bit_clks(input int id);
    return (id == 0) ? 16 * 81 : 16 * 8;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // par < 0: no parity bit. rdy_at >= 0: read_ready high for the single clock at that offset.
  task automatic send_frame(input int id, input logic [7:0] data, input int par,
                            input logic stop, input int rdy_at);
    logic [15:0] bits;
    int n, cnt;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1 + i] = data[i];
    n = 9;
    if (par >= 0) begin
      bits[n] = par[0];
      n++;
    end
    bits[n] = stop;
    n++;
    cnt = 0;
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < bit_clks(id); c++) begin
        @(negedge clock);
        rx_l[id] = bits[b];
        if (rdy_at >= 0) rdy[id] = (cnt == rdy_at);
        cnt++;
      end
    end
  endtask

  task automatic wait_valid(input int id, input string tag, input int budget);
    int k;
    k = 0;
    while (!vld[id] && k < budget) begin
      @(negedge clock);
      k++;
    end
    chk({tag, "_valid"}, vld[id], 1);
  endtask

  task automatic check_word(input int id, input string tag);
    exp_t e;
    wait_valid(id, tag, 4000);
    e = sb.pop_front();
    chk({tag, "_data"}, rd[id], e.data);
    chk({tag, "_perr"}, pe[id], e.pe);
    chk({tag, "_ferr"}, fe[id], e.fe);
    chk({tag, "_brk"},  bk[id], e.bk);
    chk({tag, "_ovr"},  ov[id], e.ov);
  endtask

  task automatic consume(input int id, input string tag);
    @(negedge clock);
    rdy[id] = 1'b1;
    @(negedge clock);
    rdy[id] = 1'b0;
    chk({tag, "_consumed"}, vld[id], 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rx_l[i] = 1'b1;
      rdy[i]  = 1'b0;
    end
    reset_n = 1'b0;
    idle(5);
    chk("rst_valid", vld[0], 0);
    chk("rst_data",  rd[0],  0);
    chk("rst_flags", {pe[0], fe[0], bk[0], ov[0]}, 0);
    chk("rst_busy",  bz[0],  0);
    reset_n = 1'b1;
    idle(20);

    // Default configuration, plain word, held until read
    sb.push_back('{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0});
    send_frame(0, 8'hA5, -1, 1'b1, -1);
    check_word(0, "a5");
    idle(200);
    chk("a5_hold_valid", vld[0], 1);
    chk("a5_hold_data",  rd[0],  8'hA5);
    consume(0, "a5");

    // Three-sample glitch is a false start
    @(negedge clock);
    rx_l[0] = 1'b0;
    idle(100);
    chk("glitch_busy", bz[0], 1);
    idle(143);
    rx_l[0] = 1'b1;
    idle(1300);
    chk("glitch_idle",  bz[0],  0);
    chk("glitch_noval", vld[0], 0);
    sb.push_back('{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0});
    send_frame(0, 8'h3C, -1, 1'b1, -1);
    check_word(0, "3c");
    consume(0, "3c");

    // Even parity
    sb.push_back('{8'h03, 1'b1, 1'b0, 1'b0, 1'b0});
    send_frame(2, 8'h03, 1, 1'b1, -1);
    check_word(2, "par_bad");
    consume(2, "par_bad");
    sb.push_back('{8'h03, 1'b0, 1'b0, 1'b0, 1'b0});
    send_frame(2, 8'h03, 0, 1'b1, -1);
    check_word(2, "par_ok");
    consume(2, "par_ok");

    // Stop bit low: frame error, no re-arm while the line stays low
    sb.push_back('{8'h5A, 1'b0, 1'b1, 1'b0, 1'b0});
    send_frame(1, 8'h5A, -1, 1'b0, -1);
    idle(300);
    check_word(1, "ferr");
    chk("ferr_not_rearmed", bz[1], 0);
    consume(1, "ferr");
    rx_l[1] = 1'b1;
    idle(200);

    // Back-to-back with no reads: overrun; third completes on a read cycle
    send_frame(1, 8'h11, -1, 1'b1, -1);
    sb.push_back('{8'h22, 1'b0, 1'b0, 1'b0, 1'b1});
    send_frame(1, 8'h22, -1, 1'b1, -1);
    check_word(1, "ovr");
    sb.push_back('{8'h33, 1'b0, 1'b0, 1'b0, 1'b0});
    send_frame(1, 8'h33, -1, 1'b1, 1226);
    check_word(1, "same_cycle");
    consume(1, "same_cycle");
    idle(50);

    // Break: line low for two frame times gives a single word
    sb.push_back('{8'h00, 1'b0, 1'b1, 1'b1, 1'b0});
    @(negedge clock);
    rx_l[1] = 1'b0;
    idle(2560);
    rx_l[1] = 1'b1;
    idle(300);
    check_word(1, "brk");
    consume(1, "brk");
    idle(1500);
    chk("brk_single", vld[1], 0);

    // Asynchronous reset mid-frame with a word held
    sb.push_back('{8'h7E, 1'b0, 1'b0, 1'b0, 1'b0});
    send_frame(1, 8'h7E, -1, 1'b1, -1);
    check_word(1, "pre_rst");
    @(negedge clock);
    rx_l[1] = 1'b0;
    idle(500);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", vld[1], 0);
    chk("mid_rst_data",  rd[1],  0);
    chk("mid_rst_flags", {pe[1], fe[1], bk[1], ov[1]}, 0);
    chk("mid_rst_busy",  bz[1],  0);
    rx_l[1] = 1'b1;
    idle(3);
    reset_n = 1'b1;
    idle(300);
    chk("post_rst_idle", {bz[1], vld[1]}, 0);
    sb.push_back('{8'hC3, 1'b0, 1'b0, 1'b0, 1'b0});
    send_frame(1, 8'hC3, -1, 1'b1, -1);
    check_word(1, "c3");
    consume(1, "c3");
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
